// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - pipe field generator and scroller for the 16x16 Flappy Bird matrix
// Pipes enter at column 0, move toward column 15, and are scored as they leave the bird column.
module pipe_scroller #(
    parameter int          STEP_DIV     = 25_000_000,
    parameter int          PIPE_SPACING = 6,
    parameter int          GAP_H        = 4,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              freeze,
    output logic [15:0][15:0] green,
    output logic              step,
    output logic [7:0]        score
);

    localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int SW = (PIPE_SPACING > 2) ? $clog2(PIPE_SPACING) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(STEP_DIV - 1);
    localparam logic [SW-1:0] SPACE_LAST = SW'(PIPE_SPACING - 1);
    localparam logic [7:0]    GAP_RANGE  = 8'(15 - GAP_H);
    localparam logic [4:0]    GAP_H5     = 5'(GAP_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCROLL,
        S_FROZEN
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [SW-1:0]     space_q, space_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [7:0]        score_q, score_d;
    logic              step_q, step_d;
    logic [15:0][15:0] green_q, green_d;

    logic [4:0]        gap_lo;
    logic [4:0]        gap_hi;
    logic [15:0]       pipe_col;
    logic [15:0]       inject_col;
    logic [15:0][15:0] shifted;
    logic              col14_lit;

    // Column contents for this step; the gap is drawn from the LFSR value of the step cycle.
    always_comb begin
        gap_lo     = 5'(lfsr_q % GAP_RANGE) + 5'd1;
        gap_hi     = gap_lo + GAP_H5;
        pipe_col   = '0;
        inject_col = '0;
        shifted    = '0;
        col14_lit  = 1'b0;
        for (int r = 0; r < 16; r++) begin
            pipe_col[r] = (5'(r) < gap_lo) || (5'(r) >= gap_hi);
        end
        inject_col = (space_q == '0) ? pipe_col : 16'h0000;
        for (int r = 0; r < 16; r++) begin
            shifted[r] = {green_q[r][14:0], inject_col[r]};
            col14_lit  = col14_lit | green_q[r][14];
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        space_d = space_q;
        score_d = score_q;
        green_d = green_q;
        step_d  = 1'b0;
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (!run) begin
            state_d = S_IDLE;
            tick_d  = '0;
            green_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SCROLL;
                    score_d = 8'd0;
                    tick_d  = '0;
                    space_d = '0;
                end
                S_SCROLL: begin
                    if (freeze) begin
                        state_d = S_FROZEN;
                        tick_d  = '0;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        green_d = shifted;
                        step_d  = 1'b1;
                        space_d = (space_q == SPACE_LAST) ? '0 : space_q + 1'b1;
                        if (col14_lit && score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_FROZEN: begin
                    tick_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            space_q <= '0;
            lfsr_q  <= LFSR_SEED;
            score_q <= 8'd0;
            step_q  <= 1'b0;
            green_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            space_q <= space_d;
            lfsr_q  <= lfsr_d;
            score_q <= score_d;
            step_q  <= step_d;
            green_q <= green_d;
        end
    end

    assign green = green_q;
    assign step  = step_q;
    assign score = score_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb/tb_pipe_scroller.sv - self-checking bench for pipe_scroller
// Cycle-level reference model of the pipe field plus timing tables and directed corner cases.
module tb_pipe_scroller;

    localparam int STEP_DIV     = 4;
    localparam int PIPE_SPACING = 6;
    localparam int GAP_H        = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              freeze = 1'b0;
    logic [15:0][15:0] green;
    logic              step;
    logic [7:0]        score;

    always #5 clk = ~clk;

    pipe_scroller #(
        .STEP_DIV     (STEP_DIV),
        .PIPE_SPACING (PIPE_SPACING),
        .GAP_H        (GAP_H),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .freeze (freeze),
        .green  (green),
        .step   (step),
        .score  (score)
    );

    int total = 0;
    int bad   = 0;
    int cnt   = 0;

    // Model state: 0 idle, 1 scroll, 2 frozen; columns stored as 16-bit row masks.
    int          m_mode;
    int          m_cyc;
    int          m_steps;
    int          m_gap;
    logic [15:0] m_col [16];
    logic [7:0]  m_score;
    logic        m_step;
    logic [7:0]  m_lfsr;

    typedef struct {
        int         cyc;
        logic       exp_step;
        logic [7:0] exp_score;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        int fb = 0;
        for (int b = 3; b < 8; b++) begin
            if (b != 6 && l[b]) fb = fb + 1;
        end
        return 8'((int'(l) * 2) % 256 + fb % 2);
    endfunction

    function automatic int gap_of(input logic [7:0] l);
        return 1 + int'(l) % (15 - GAP_H);
    endfunction

    function automatic logic [15:0] pipe_of(input int top);
        logic [15:0] v = 16'hFFFF;
        for (int i = 0; i < GAP_H; i++) v[top + i] = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] col_of(input logic [15:0][15:0] g, input int c);
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = g[r][c];
        return v;
    endfunction

    function automatic logic [15:0][15:0] model_green();
        logic [15:0][15:0] g;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                g[r][c] = m_col[c][r];
        return g;
    endfunction

    task automatic model_edge();
        logic [7:0] l_pre;
        if (rst) begin
            m_mode = 0; m_cyc = 0; m_steps = 0;
            m_score = 8'd0; m_step = 1'b0; m_lfsr = 8'hA5;
            for (int c = 0; c < 16; c++) m_col[c] = 16'h0;
            return;
        end
        l_pre  = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        m_step = 1'b0;
        if (!run) begin
            m_mode = 0;
            for (int c = 0; c < 16; c++) m_col[c] = 16'h0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_score = 8'd0; m_cyc = 0; m_steps = 0;
        end else if (m_mode == 1) begin
            if (freeze) begin
                m_mode = 2;
            end else begin
                m_cyc++;
                if (m_cyc % STEP_DIV == 0) begin
                    if (m_col[14] != 16'h0 && m_score < 8'd255) m_score++;
                    for (int c = 15; c > 0; c--) m_col[c] = m_col[c - 1];
                    if (m_steps % PIPE_SPACING == 0) begin
                        m_gap    = gap_of(l_pre);
                        m_col[0] = pipe_of(m_gap);
                    end else begin
                        m_col[0] = 16'h0;
                    end
                    m_steps++;
                    m_step = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cnt=%0d: got %h expected %h", name, cnt, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cnt++;
        check("green", green, model_green());
        check("score", 256'(score), 256'(m_score));
        check("step", 256'(step), 256'(m_step));
    endtask

    task automatic start_run();
        run = 1'b1;
        cyc();
        cnt = 0;
    endtask

    logic [15:0] first_col;
    logic [15:0] c0;
    int          dark;
    int          first_dark;
    int          pulses;

    initial begin
        tbl[0] = '{3,  1'b0, 8'd0};
        tbl[1] = '{4,  1'b1, 8'd0};
        tbl[2] = '{5,  1'b0, 8'd0};
        tbl[3] = '{8,  1'b1, 8'd0};
        tbl[4] = '{60, 1'b1, 8'd0};
        tbl[5] = '{63, 1'b0, 8'd0};
        tbl[6] = '{64, 1'b1, 8'd1};
        tbl[7] = '{65, 1'b0, 8'd1};
        tbl[8] = '{84, 1'b1, 8'd1};
        tbl[9] = '{88, 1'b1, 8'd2};

        // Reset and idle
        rst = 1'b1; run = 1'b0; freeze = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            check("idle_green", green, '0);
            check("idle_step", 256'(step), 256'(0));
        end

        // First pipe, scroll and scoring timing
        start_run();
        for (int i = 0; i < 10; i++) begin
            while (cnt < tbl[i].cyc) cyc();
            check("tbl_step", 256'(step), 256'(tbl[i].exp_step));
            check("tbl_score", 256'(score), 256'(tbl[i].exp_score));
            if (tbl[i].cyc == 4) begin
                c0 = col_of(green, 0);
                first_col = m_col[0];
                dark = 0; first_dark = -1;
                for (int r = 0; r < 16; r++) begin
                    if (!c0[r]) begin
                        dark++;
                        if (first_dark < 0) first_dark = r;
                    end
                end
                check("first_row0", 256'(c0[0]), 256'(1));
                check("first_row15", 256'(c0[15]), 256'(1));
                check("first_dark", 256'(dark), 256'(GAP_H));
                check("first_gap_top", 256'(first_dark), 256'(m_gap));
                check("first_col_pat", 256'(c0), 256'(pipe_of(m_gap)));
                for (int c = 1; c < 16; c++) check("first_rest", 256'(col_of(green, c)), 256'(0));
            end
            if (tbl[i].cyc == 60) begin
                check("col14_lit", 256'(col_of(green, 14) != 16'h0), 256'(1));
                check("col8_lit", 256'(col_of(green, 8) != 16'h0), 256'(1));
                check("col2_lit", 256'(col_of(green, 2) != 16'h0), 256'(1));
                check("col13_dark", 256'(col_of(green, 13)), 256'(0));
            end
        end

        // Freeze on the tick_cnt==3 cycle
        while (cnt % STEP_DIV != STEP_DIV - 1) cyc();
        freeze = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (step) pulses++;
        end
        check("frozen_pulses", 256'(pulses), 256'(0));
        check("frozen_score", 256'(score), 256'(2));
        freeze = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (step) pulses++;
        end
        check("unfreeze_pulses", 256'(pulses), 256'(0));
        run = 1'b0;
        cyc();
        check("run_low_clear", green, '0);

        // Reset during a step-event cycle, then replay the opening sequence
        repeat (5) cyc();
        start_run();
        while (cnt < 30 || cnt % STEP_DIV != STEP_DIV - 1) cyc();
        rst = 1'b1;
        cyc();
        check("rst_green", green, '0);
        check("rst_score", 256'(score), 256'(0));
        check("rst_step", 256'(step), 256'(0));
        cyc(); cyc();
        rst = 1'b0; run = 1'b0;
        repeat (50) cyc();
        start_run();
        while (cnt < 4) cyc();
        check("replay_step", 256'(step), 256'(1));
        check("replay_col0", 256'(col_of(green, 0)), 256'(first_col));

        // Saturation
        run = 1'b0;
        cyc();
        start_run();
        for (int i = 0; i < 6400; i++) cyc();
        check("sat_score", 256'(score), 256'(255));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (step) pulses++;
        end
        check("sat_pulses", 256'(pulses), 256'(10));
        check("sat_score_hold", 256'(score), 256'(255));

        // Randomized run/freeze/rst traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 499) == 0);
            run    = ($urandom_range(0, 199) != 0);
            freeze = ($urandom_range(0, 149) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
